// File: rtl/map_pkg.sv
// map_pkg -- constants and block-state encodings shared by the map renderer.
//   MAP_ROWS / MAP_COLS : map store geometry in tiles
//   SCROLL_MAX          : horizontal world width in pixels (MAP_COLS * 32)
//   block_state_t       : cell state codes returned by the map store
//   wrap_scroll()       : single conditional subtract that folds a sum into 0..SCROLL_MAX-1
package map_pkg;

  localparam int MAP_ROWS   = 5;
  localparam int MAP_COLS   = 100;
  localparam int SCROLL_MAX = 3200;

  typedef enum logic [2:0] {
    EMPTY  = 3'b000,
    SOLID  = 3'b001,
    HAZARD = 3'b010
  } block_state_t;

  // Both callers add values whose sum stays below 2*SCROLL_MAX, so one
  // conditional subtract is enough to wrap.
  function automatic logic [12:0] wrap_scroll(input logic [12:0] sum);
    if (sum >= 13'(SCROLL_MAX)) return sum - 13'(SCROLL_MAX);
    else                        return sum;
  endfunction

endpackage

// File: rtl/map_scroll_ctr.sv
// map_scroll_ctr -- horizontal scroll position of the map.
//   clk, rst        : clock, asynchronous active-high reset
//   frame_start     : one-cycle pulse per frame; advances the scroll when run=1
//   run, speed[3:0] : scroll enable and pixels advanced per frame
//   scroll_px[11:0] : current scroll offset in pixels, 0..SCROLL_MAX-1
//   scroll_col[6:0] : registered scroll_px / TILE_W (leftmost visible column)
module map_scroll_ctr
  import map_pkg::*;
#(
  parameter int TILE_W = 32
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        frame_start,
  input  logic        run,
  input  logic [3:0]  speed,
  output logic [11:0] scroll_px,
  output logic [6:0]  scroll_col
);

  localparam int SHIFT = $clog2(TILE_W);

  logic [12:0] sum;
  logic [12:0] wrapped;
  logic [11:0] next_px;

  always_comb begin
    sum     = {1'b0, scroll_px} + {9'd0, speed};
    wrapped = wrap_scroll(sum);
    next_px = scroll_px;
    if (frame_start && run) next_px = wrapped[11:0];
  end

  // scroll_col is loaded from the same next value so it never lags scroll_px.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      scroll_px  <= '0;
      scroll_col <= '0;
    end else begin
      scroll_px  <= next_px;
      scroll_col <= 7'(next_px >> SHIFT);
    end
  end

endmodule

// File: rtl/map_render.sv
// map_render -- two-stage tile renderer for a horizontally scrolling map.
//   clk, rst                 : clock, asynchronous active-high reset
//   frame_start, run, speed  : scroll control (see map_scroll_ctr)
//   pix_valid, pix_x, pix_y  : pixel request from the VGA timing stage
//   map_index_y/x            : registered address to the map store
//   map_r/g/b, map_state     : combinational cell data from the map store
//   out_valid, out_r/g/b,
//   out_state                : rendered pixel, 2 cycles after the request
//   scroll_col               : leftmost visible map column
// Build option: define MAP_GRID_EN to blank the colour on tile borders.
module map_render
  import map_pkg::*;
#(
  parameter int TILE_W = 32,
  parameter int TILE_H = 96
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       frame_start,
  input  logic       run,
  input  logic [3:0] speed,
  input  logic       pix_valid,
  input  logic [9:0] pix_x,
  input  logic [9:0] pix_y,
  output logic [2:0] map_index_y,
  output logic [6:0] map_index_x,
  input  logic [3:0] map_r,
  input  logic [3:0] map_g,
  input  logic [3:0] map_b,
  input  logic [2:0] map_state,
  output logic       out_valid,
  output logic [3:0] out_r,
  output logic [3:0] out_g,
  output logic [3:0] out_b,
  output logic [2:0] out_state,
  output logic [6:0] scroll_col
);

  localparam int SHIFT = $clog2(TILE_W);

  logic [11:0] scroll_px;

  map_scroll_ctr #(.TILE_W(TILE_W)) u_scroll (
    .clk        (clk),
    .rst        (rst),
    .frame_start(frame_start),
    .run        (run),
    .speed      (speed),
    .scroll_px  (scroll_px),
    .scroll_col (scroll_col)
  );

  // Row lookup by compare chain; anything past the last row clamps to row 4.
  function automatic logic [2:0] row_of(input logic [9:0] y);
    int yi;
    yi = int'(y);
    if      (yi < TILE_H)     return 3'd0;
    else if (yi < 2 * TILE_H) return 3'd1;
    else if (yi < 3 * TILE_H) return 3'd2;
    else if (yi < 4 * TILE_H) return 3'd3;
    else                      return 3'd4;
  endfunction

  // scroll_px is the pre-update value here, so a pixel issued on a
  // scroll-update cycle still sees the old offset.
  logic [12:0] world_x;
  always_comb begin
    world_x = wrap_scroll({3'd0, pix_x} + {1'b0, scroll_px});
  end

`ifdef MAP_GRID_EN
  function automatic logic on_row_line(input logic [9:0] y);
    logic hit;
    hit = 1'b0;
    for (int k = 0; k <= 1023 / TILE_H; k++)
      if (int'(y) == k * TILE_H) hit = 1'b1;
    return hit;
  endfunction

  logic grid_p1;
  always_ff @(posedge clk or posedge rst) begin
    if (rst)            grid_p1 <= 1'b0;
    else if (pix_valid) grid_p1 <= ((world_x & 13'(TILE_W - 1)) == 13'd0) || on_row_line(pix_y);
  end
`endif

  // ---- stage 1: map address ----
  logic vld_p1;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_p1      <= 1'b0;
      map_index_x <= '0;
      map_index_y <= '0;
    end else begin
      vld_p1 <= pix_valid;
      if (pix_valid) begin
        map_index_x <= 7'(world_x >> SHIFT);
        map_index_y <= row_of(pix_y);
      end
    end
  end

  // ---- stage 2: cell data capture ----
  logic blank;
`ifdef MAP_GRID_EN
  assign blank = grid_p1;
`else
  assign blank = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_r     <= '0;
      out_g     <= '0;
      out_b     <= '0;
      out_state <= EMPTY;
    end else begin
      out_valid <= vld_p1;
      if (vld_p1) begin
        out_r     <= blank ? 4'd0 : map_r;
        out_g     <= blank ? 4'd0 : map_g;
        out_b     <= blank ? 4'd0 : map_b;
        out_state <= map_state;
      end else begin
        out_r     <= '0;
        out_g     <= '0;
        out_b     <= '0;
        out_state <= EMPTY;
      end
    end
  end

endmodule

// File: doc/map_render.md
MAP_RENDER -- requirements
Module: map_render

Interface
REQ-001 SHALL have parameter TILE_W, default 32, tile width in pixels, power of two.
REQ-002 SHALL have parameter TILE_H, default 96, tile height in pixels.
REQ-003 SHALL have ports `clk` (input, 1): single clock; everything is rising-edge.
REQ-004 SHALL have port `rst` (input, 1): reset, asynchronous and active-high.
REQ-005 SHALL have port `frame_start` (input, 1): one-cycle pulse per frame.
REQ-006 SHALL have port `run` (input, 1): scrolling enable.
REQ-007 SHALL have port `speed` (input, 4): pixels scrolled per frame.
REQ-008 SHALL have ports `pix_valid` (input, 1), `pix_x` (input, 10) and `pix_y` (input, 10): pixel request from the VGA timing stage.
REQ-009 SHALL have ports `map_index_y` (output, 3) and `map_index_x` (output, 7): address to the map store.
REQ-010 SHALL have ports `map_r`, `map_g`, `map_b` (input, 4 each) and `map_state` (input, 3): combinational cell data returned by the map store.
REQ-011 SHALL have port `out_valid` (output, 1).
REQ-012 SHALL have ports `out_r`, `out_g`, `out_b` (output, 4 each) and `out_state` (output, 3): rendered pixel.
REQ-013 SHALL have port `scroll_col` (output, 7): leftmost visible map column, for collision logic.

Function
REQ-014 SHALL hold scroll_px, range 0..MAP_COLS*TILE_W-1 (0..3199).
REQ-015 SHALL set scroll_px to (scroll_px+speed) mod 3200 on a frame_start cycle with run=1; otherwise scroll_px holds. speed=0 means no motion.
REQ-016 SHALL perform the wrap as a single conditional subtract of 3200 when the sum is 3200 or more.
REQ-017 SHALL, in stage 1 on a pix_valid=1 cycle, register world_x=(pix_x+scroll_px) mod 3200.
REQ-018 SHALL register map_index_x=world_x/TILE_W, implemented as a shift.
REQ-019 SHALL register map_index_y=pix_y/TILE_H using a compare chain, clamped to 4.
REQ-020 SHALL register the stage-1 valid bit.
REQ-021 SHALL, in stage 2, register map_r/g/b/state into out_* and the stage-1 valid bit into out_valid.
REQ-022 SHALL have a latency of exactly 2 cycles from pix_valid to out_valid, with throughput of 1 pixel per cycle.
REQ-023 SHALL drive out_valid=0, out_r/g/b=0 and out_state=0 (EMPTY) for a pixel whose stage-1 valid bit is 0.
REQ-024 SHALL use the pre-update scroll_px for any pixel issued in the same cycle as a scroll update; the new value applies from the next cycle.
REQ-025 SHALL drive scroll_col=scroll_px/TILE_W, registered.
REQ-026 SHALL drive map_index_y/map_index_x only from flops.

Reset
REQ-027 SHALL, while rst is high, clear scroll_px, both pipeline stages, map_index_y/x, scroll_col and all out_* to 0.
REQ-028 SHALL discard in-flight pixels on reset; the first valid output appears 2 cycles after the first pix_valid following deassertion.

Configuration
REQ-029 SHALL, when MAP_GRID_EN is defined, force out_r/g/b to 0 when world_x mod TILE_W==0 or pix_y is a multiple of TILE_H; out_state is still the cell state and latency is unchanged.
REQ-030 SHALL, when MAP_GRID_EN is undefined, omit the grid logic and output pure tile colour.

Structure
REQ-031 SHALL take the following from shared package map_pkg: MAP_ROWS=5, MAP_COLS=100, SCROLL_MAX=3200, and the block-state encodings EMPTY=3'b000, SOLID=3'b001, HAZARD=3'b010.
REQ-032 SHALL put the scroll counter (REQ-014..016, 025) in sub-module map_scroll_ctr; the pipeline stays in map_render.

Verification
REQ-033 SHALL cover: after reset, with scroll 0, pix (0,0) valid -> map index (0,0) after 1 cycle; out_valid=1 after 2 cycles with rgb F,0,0 and state 010.
REQ-034 SHALL cover: scroll_px=3190, speed=15, run=1, frame_start -> scroll_px=5 and scroll_col=0; with run=0, scroll_px is unchanged.
REQ-035 SHALL cover: scroll_px=3199, pix_x=0 -> index_x=99; pix_x=1 -> index_x=0.
REQ-036 SHALL cover: pix (639,479) at scroll 0 -> index (4,19); pix_y=95/96 -> index_y 0/1.
REQ-037 SHALL cover: pix (32,10) with MAP_GRID_EN defined -> rgb 0,0,0 and state 000; with it undefined -> rgb F,0,0 and state 000.
REQ-038 SHALL cover: rst asserted mid-stream with pix_valid continuous -> outputs 0 immediately, with out_valid returning exactly 2 cycles after release.
